alu_instr_sequencer: RTL and testbench

Initiator for the ALU/instruction-memory datapath. It holds a small loadable program of {save, opcode, a, b} words. On start it walks the program in order. For each instruction it drives operands and opcode to the datapath, waits a fixed settle time, then samples the result. It accumulates an 8-bit checksum and a carry count, and pulses done at the end of the program. This replaces hand-written stimulus as the driver of the datapath.

---
 rtl/alu_instr_sequencer_pkg.sv | 51 +++++
 rtl/alu_prog_mem.sv | 25 ++
 rtl/alu_instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared encodings for the ALU program sequencer:
// opcodes, FSM states and instruction word layout.
package alu_instr_sequencer_pkg;

   localparam int INSTR_W  = 20;
   localparam int SAVE_BIT = 19;
   localparam int OP_HI    = 18;
   localparam int OP_LO    = 16;
   localparam int A_HI     = 15;
   localparam int A_LO     = 8;
   localparam int B_HI     = 7;
   localparam int B_LO     = 0;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5,
      OP_DIV = 3'd6,
      OP_CMP = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   typedef struct packed {
      logic       save;
      opcode_e    opcode;
      logic [7:0] a;
      logic [7:0] b;
   } instr_t;

   function automatic instr_t unpack_instr(
      input logic [INSTR_W-1:0] w
   );
      instr_t i;
      i.save   = w[SAVE_BIT];
      i.opcode = opcode_e'(w[OP_HI:OP_LO]);
      i.a      = w[A_HI:A_LO];
      i.b      = w[B_HI:B_LO];
      return i;
   endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x 20 register file,
// synchronous write, asynchronous read, no reset.
module alu_prog_mem
   import alu_instr_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Walks a loaded program through the ALU datapath,
// capturing results into a checksum and carry count.
module alu_instr_sequencer
   import alu_instr_sequencer_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   input  logic [AW-1:0]      load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [AW:0]        prog_len,
   input  logic               start,
   input  logic               abort,
   output logic [7:0]         a,
   output logic [7:0]         b,
   output logic [2:0]         opcode,
   output logic               save,
   input  logic [7:0]         alu_out,
   input  logic               carry_out,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      pc,
   output logic [7:0]         last_result,
   output logic [7:0]         checksum,
   output logic [7:0]         carry_count
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_e             state;
   state_e             state_nx;
   logic [AW:0]        len_q;
   logic [CW-1:0]      wait_cnt;
   logic [INSTR_W-1:0] rd_word;
   instr_t             cur;
   logic               wr_en;
   logic               last_instr;
   logic               wait_end;
   logic               capture;
   logic               running;

   alu_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (pc),
      .rdata (rd_word)
   );

   // Start wins over a same-cycle load.
   assign wr_en      = (state == S_IDLE) && load_en && !start;
   assign cur        = unpack_instr(rd_word);
   assign last_instr = ({1'b0, pc} == (len_q - 1'b1));
   assign wait_end   = (wait_cnt == CW'(WAIT_CYCLES - 1));
   assign capture    = (state == S_CAPTURE) && !abort;
   assign running    = (state == S_ISSUE) ||
                       (state == S_WAIT) ||
                       (state == S_CAPTURE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (start)
               state_nx = (prog_len == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE:   state_nx = S_WAIT;
         S_WAIT:    if (wait_end) state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = last_instr ? S_DONE : S_ISSUE;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) state_nx = S_IDLE;
   end

   // Operands come straight from mem[pc]; the program
   // cannot change while running, so they stay stable.
   always_comb begin
      a      = '0;
      b      = '0;
      opcode = '0;
      busy   = 1'b0;
      save   = 1'b0;
      done   = 1'b0;
      unique case (1'b1)
         running: begin
            a      = cur.a;
            b      = cur.b;
            opcode = cur.opcode;
            busy   = 1'b1;
            save   = (state == S_CAPTURE) && cur.save;
         end
         (state == S_DONE): done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         len_q       <= '0;
         wait_cnt    <= '0;
         last_result <= '0;
         checksum    <= '0;
         carry_count <= '0;
      end else begin
         if ((state == S_IDLE) && start) begin
            len_q       <= prog_len;
            pc          <= '0;
            checksum    <= '0;
            carry_count <= '0;
         end
         if (state == S_ISSUE)
            wait_cnt <= '0;
         else if ((state == S_WAIT) && !wait_end)
            wait_cnt <= wait_cnt + 1'b1;
         if (capture) begin
            last_result <= alu_out;
            checksum    <= checksum + alu_out;
            if (carry_out && (carry_count != 8'hFF))
               carry_count <= carry_count + 1'b1;
            if (!last_instr) pc <= pc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomised and directed bench for alu_instr_sequencer
// with a behavioural datapath and program-level model.
module tb_alu_instr_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int WC    = 1;
   localparam int IC    = WC + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [19:0]   load_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic          abort;
   logic [7:0]    a;
   logic [7:0]    b;
   logic [2:0]    opcode;
   logic          save;
   logic [7:0]    alu_out;
   logic          carry_out;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;
   logic [7:0]    last_result;
   logic [7:0]    checksum;
   logic [7:0]    carry_count;

   int          checks = 0;
   int          errors = 0;
   logic [19:0] prog [DEPTH];
   bit          force_carry = 1'b0;
   logic [8:0]  dp_r;

   alu_instr_sequencer #(
      .DEPTH       (DEPTH),
      .AW          (AW),
      .WAIT_CYCLES (WC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .prog_len    (prog_len),
      .start       (start),
      .abort       (abort),
      .a           (a),
      .b           (b),
      .opcode      (opcode),
      .save        (save),
      .alu_out     (alu_out),
      .carry_out   (carry_out),
      .busy        (busy),
      .done        (done),
      .pc          (pc),
      .last_result (last_result),
      .checksum    (checksum),
      .carry_count (carry_count)
   );

   always #5 clk = ~clk;

   // Datapath: {carry, result} for one operation.
   function automatic logic [8:0] dp(
      input logic [2:0] op,
      input logic [7:0] x,
      input logic [7:0] y
   );
      logic [15:0] m;
      logic [8:0]  r;
      m = 16'(x) * 16'(y);
      case (op)
         3'd0:    r = {1'b0, x} + {1'b0, y};
         3'd1:    r = {1'b0, x} - {1'b0, y};
         3'd2:    r = {1'b0, x & y};
         3'd3:    r = {1'b0, x | y};
         3'd4:    r = {1'b0, x ^ y};
         3'd5:    r = {1'b0, m[7:0]};
         3'd6:    r = {1'b0, (y == 8'd0) ? 8'hFF : x / y};
         default: r = {1'b0, (x == y) ? 8'h01 : 8'h00};
      endcase
      return r;
   endfunction

   always_comb begin
      dp_r      = dp(opcode, a, b);
      alu_out   = dp_r[7:0];
      carry_out = dp_r[8] | force_carry;
   end

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_all();
      for (int i = 0; i < DEPTH; i++) begin
         load_en   = 1'b1;
         load_addr = AW'(i);
         load_data = prog[i];
         @(negedge clk);
      end
      load_en = 1'b0;
   endtask

   task automatic load_directed();
      prog[0] = {1'b1, 3'd0, 8'h05, 8'h03};
      prog[1] = {1'b1, 3'd1, 8'hCC, 8'hAA};
      prog[2] = {1'b1, 3'd2, 8'h05, 8'h03};
      prog[3] = {1'b1, 3'd3, 8'hCC, 8'hAA};
      prog[4] = {1'b1, 3'd4, 8'h05, 8'h03};
      for (int i = 5; i < DEPTH; i++) prog[i] = 20'($urandom);
      load_all();
   endtask

   task automatic run(
      input  int len,
      input  int abort_cyc,
      input  int inj_cyc,
      output int done_cyc,
      output int saves,
      output int busy_cyc,
      output bit dbl
   );
      int cyc;
      bit prev_save;
      done_cyc  = -1;
      saves     = 0;
      busy_cyc  = 0;
      dbl       = 1'b0;
      prev_save = 1'b0;
      prog_len  = (AW + 1)'(len);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc <= 400) begin
         if (save) begin
            saves++;
            if (prev_save) dbl = 1'b1;
         end
         prev_save = save;
         if (busy) busy_cyc++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == abort_cyc) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            return;
         end
         load_en   = (cyc == inj_cyc);
         start     = (cyc == inj_cyc);
         load_addr = '0;
         load_data = 20'hFFFFF;
         @(negedge clk);
         load_en = 1'b0;
         start   = 1'b0;
         cyc++;
      end
   endtask

   task automatic run_check(
      input string tag,
      input int    len,
      input int    inj_cyc
   );
      int         dc, sv, bc;
      bit         dbl;
      logic [8:0] r;
      logic [7:0] esum, elast;
      int         ecc, esv;
      esum  = '0;
      elast = '0;
      ecc   = 0;
      esv   = 0;
      for (int i = 0; i < len; i++) begin
         r     = dp(prog[i][18:16], prog[i][15:8], prog[i][7:0]);
         esum  = esum + r[7:0];
         elast = r[7:0];
         if ((r[8] | force_carry) && ecc < 255) ecc++;
         if (prog[i][19]) esv++;
      end
      run(len, -1, inj_cyc, dc, sv, bc, dbl);
      check({tag, " done_cycle"}, dc, 1 + len * IC);
      check({tag, " checksum"}, checksum, esum);
      check({tag, " carry_count"}, carry_count, ecc);
      check({tag, " save_pulses"}, sv, esv);
      check({tag, " save_single"}, dbl, 0);
      check({tag, " busy_cycles"}, bc, len * IC);
      check({tag, " pc"}, pc, (len == 0) ? 0 : len - 1);
      if (len != 0) check({tag, " last_result"}, last_result, elast);
      @(negedge clk);
      check({tag, " idle_after"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int dc, sv, bc, ndone, total_cc;
      bit dbl;
      reset     = 1'b1;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      prog_len  = '0;
      start     = 1'b0;
      abort     = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {a, b, opcode, save, busy, done, pc},
            '0);
      check("reset_stats",
            {last_result, checksum, carry_count}, '0);
      reset = 1'b0;
      @(negedge clk);

      load_directed();
      run_check("directed", 5, -1);
      check("directed_cs_1f", checksum, 32'h1F);
      check("directed_last_06", last_result, 32'h06);

      run_check("len0", 0, -1);

      run_check("busy_inject", 5, 5);
      run_check("mem_unchanged", 5, -1);

      run(5, 2 * IC + 2, -1, dc, sv, bc, dbl);
      check("abort_idle", {busy, save}, 2'b00);
      check("abort_operands", {a, b, opcode}, '0);
      check("abort_pc", pc, 2);
      check("abort_checksum", checksum, 32'h2A);
      check("abort_last", last_result, 32'h22);
      ndone = 0;
      repeat (20) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 0);

      prog_len = 5'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset_capture", {busy, save}, 2'b11);
      #2 reset = 1'b1;
      #1;
      check("async_reset_ops",
            {a, b, opcode, save, busy, done, pc}, '0);
      check("async_reset_stats",
            {last_result, checksum, carry_count}, '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_check("after_reset", 5, -1);

      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < DEPTH; i++) prog[i] = 20'($urandom);
         load_all();
         run_check("random", int'($urandom_range(1, DEPTH)), -1);
      end

      force_carry = 1'b1;
      for (int i = 0; i < DEPTH; i++) prog[i] = 20'($urandom);
      load_all();
      total_cc = 0;
      for (int r = 0; r < 19; r++) begin
         run_check("carry16", DEPTH, -1);
         total_cc += int'(carry_count);
      end
      check("carry_total", total_cc, 19 * DEPTH);
      force_carry = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
